axil_rr_master_arb: RTL

AXIL_RR_MASTER_ARB -- requirements
Module: axil_rr_master_arb

---
 rtl/axil_rr_master_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/axil_rr_master_arb.sv
// axil_rr_master_arb: round-robin arbiter letting two requesters share one AXI4-Lite master port.
// One transaction is outstanding at a time; completion is reported by a one-cycle req_done pulse.
// Optional response watchdog: define AXIL_RR_MASTER_ARB_TIMEOUT_EN.
module axil_rr_master_arb #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_done,
    output logic [DATA_WIDTH-1:0]   req_rdata,
    output logic [1:0]              req_resp,
    output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [3:0]              M_AXI_WSTRB,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY
);

    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;

    // Elaboration guard on unsupported configurations
    if (DW != 32 || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("axil_rr_master_arb: DATA_WIDTH must be 32 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [2:0] {IDLE, DONE, WR, WRESP, RD, RRESP} state_e;

    state_e          state_q, state_d;
    logic            idx_q, idx_d;
    logic            last_q, last_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic [1:0]      done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic            grant_c;

`ifdef AXIL_RR_MASTER_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Winner: the only valid requester, or the one not served last when both ask
    assign grant_c = (&req_valid) ? ~last_q : ~req_valid[0];

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        done_d    = 2'b00;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef AXIL_RR_MASTER_ARB_TIMEOUT_EN
        cnt_d     = cnt_q + CNT_W'(1);
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    idx_d   = grant_c;
                    addr_d  = grant_c ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
                    wdata_d = grant_c ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
`ifdef AXIL_RR_MASTER_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    if (req_write[grant_c]) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (M_AXI_BVALID) begin
                    state_d  = DONE;
                    bready_d = 1'b0;
                    resp_d   = M_AXI_BRESP;
                    rdata_d  = '0;
                    done_d   = idx_q ? 2'b10 : 2'b01;
                end
            end
            RD: begin
                if (M_AXI_ARREADY) begin
                    state_d   = RRESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RRESP: begin
                if (M_AXI_RVALID) begin
                    state_d  = DONE;
                    rready_d = 1'b0;
                    resp_d   = M_AXI_RRESP;
                    rdata_d  = M_AXI_RDATA;
                    done_d   = idx_q ? 2'b10 : 2'b01;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = idx_q;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXIL_RR_MASTER_ARB_TIMEOUT_EN
        // Watchdog: abandon the bus transaction and report SLVERR to the requester
        if (state_q != IDLE && state_q != DONE && state_d != DONE &&
            cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = DONE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            resp_d    = 2'b10;
            rdata_d   = '0;
            done_d    = idx_q ? 2'b10 : 2'b01;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            idx_q     <= 1'b0;
            last_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            done_q    <= 2'b00;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

`ifdef AXIL_RR_MASTER_ARB_TIMEOUT_EN
    // Watchdog counter register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    assign req_done      = done_q;
    assign req_rdata     = rdata_q;
    assign req_resp      = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = 4'hF;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule
